// File: rtl/calendar_date_counter.sv
// Day/month/year keeper over 2000..3999 with Gregorian leap rules.
// A date load is validated by an iterative century count (no divider).
module calendar_date_counter #(
    parameter logic [11:0] YEAR_MIN = 12'd2000,
    parameter logic [11:0] YEAR_MAX = 12'd3999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        day_tick,
    input  logic        set_en,
    input  logic [4:0]  set_day,
    input  logic [3:0]  set_month,
    input  logic [11:0] set_year,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [11:0] year,
    output logic        leap,
    output logic        busy,
    output logic        year_wrap
);

    typedef enum logic [1:0] {RUN, CALC, CLAMP} state_t;

    state_t      state_q, state_d;
    logic [4:0]  day_q, day_d, day_c_q, day_c_d;
    logic [3:0]  month_q, month_d, month_c_q, month_c_d;
    logic [11:0] year_q, year_d, year_c_q, year_c_d;
    logic        leap_q, leap_d, busy_q, busy_d, wrap_q, wrap_d, pend_q, pend_d;
    logic [6:0]  rem100_q, rem100_d;
    logic [4:0]  cent_q, cent_d;
    logic [10:0] r_q, r_d;

    logic [4:0]  set_day_cl;
    logic [3:0]  set_month_cl;
    logic [11:0] set_year_cl;
    logic [11:0] set_off;

    function automatic logic is_leap(input logic [11:0] yr, input logic [6:0] rem,
                                     input logic [4:0] cnt);
        logic [11:0] off;
        off = yr - YEAR_MIN;
        return (off[1:0] == 2'd0) && ((rem != 7'd0) || (cnt[1:0] == 2'd0));
    endfunction

    function automatic logic [4:0] dim_of(input logic [3:0] mo, input logic lp);
        case (mo)
            4'd2:                      return 5'd28 + {4'd0, lp};
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    assign set_day_cl   = (set_day == 5'd0) ? 5'd1 : set_day;
    assign set_month_cl = ((set_month == 4'd0) || (set_month > 4'd12)) ? 4'd1 : set_month;
    assign set_year_cl  = (set_year < YEAR_MIN) ? YEAR_MIN :
                          (set_year > YEAR_MAX) ? YEAR_MAX : set_year;
    assign set_off      = set_year_cl - YEAR_MIN;

    always_comb begin
        logic [6:0]  rem_n;
        logic [4:0]  cent_n;
        logic [11:0] yr_n;
        logic        lp_n;
        logic [4:0]  dm_n;
        rem_n     = rem100_q;
        cent_n    = cent_q;
        yr_n      = year_q;
        lp_n      = leap_q;
        dm_n      = dim_of(month_q, leap_q);
        state_d   = state_q;
        day_d     = day_q;
        month_d   = month_q;
        year_d    = year_q;
        leap_d    = leap_q;
        wrap_d    = 1'b0;
        pend_d    = pend_q;
        rem100_d  = rem100_q;
        cent_d    = cent_q;
        r_d       = r_q;
        day_c_d   = day_c_q;
        month_c_d = month_c_q;
        year_c_d  = year_c_q;

        unique case (state_q)
            RUN: begin
                if (set_en) begin
                    day_c_d   = set_day_cl;
                    month_c_d = set_month_cl;
                    year_c_d  = set_year_cl;
                    r_d       = set_off[10:0];
                    cent_d    = 5'd0;
                    pend_d    = 1'b0;
                    state_d   = CALC;
                end else if (day_tick || pend_q) begin
                    pend_d = 1'b0;
                    if (day_q < dm_n) begin
                        day_d = day_q + 5'd1;
                    end else if (month_q < 4'd12) begin
                        day_d   = 5'd1;
                        month_d = month_q + 4'd1;
                    end else begin
                        day_d   = 5'd1;
                        month_d = 4'd1;
                        if (year_q == YEAR_MAX) begin
                            yr_n   = YEAR_MIN;
                            rem_n  = 7'd0;
                            cent_n = 5'd0;
                            wrap_d = 1'b1;
                        end else begin
                            yr_n   = year_q + 12'd1;
                            rem_n  = (rem100_q == 7'd99) ? 7'd0 : rem100_q + 7'd1;
                            cent_n = (rem100_q == 7'd99) ? cent_q + 5'd1 : cent_q;
                        end
                        year_d   = yr_n;
                        rem100_d = rem_n;
                        cent_d   = cent_n;
                        leap_d   = is_leap(yr_n, rem_n, cent_n);
                    end
                end
            end
            CALC: begin
                pend_d = pend_q | day_tick;
                if (r_q >= 11'd100) begin
                    r_d    = r_q - 11'd100;
                    cent_d = cent_q + 5'd1;
                end else begin
                    rem100_d = r_q[6:0];
                    state_d  = CLAMP;
                end
            end
            CLAMP: begin
                pend_d  = pend_q | day_tick;
                lp_n    = is_leap(year_c_q, rem100_q, cent_q);
                dm_n    = dim_of(month_c_q, lp_n);
                leap_d  = lp_n;
                year_d  = year_c_q;
                month_d = month_c_q;
                day_d   = (day_c_q > dm_n) ? dm_n : day_c_q;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        busy_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            day_q     <= 5'd1;
            month_q   <= 4'd1;
            year_q    <= YEAR_MIN;
            leap_q    <= 1'b1;
            busy_q    <= 1'b0;
            wrap_q    <= 1'b0;
            pend_q    <= 1'b0;
            rem100_q  <= 7'd0;
            cent_q    <= 5'd0;
            r_q       <= 11'd0;
            day_c_q   <= 5'd1;
            month_c_q <= 4'd1;
            year_c_q  <= YEAR_MIN;
        end else begin
            state_q   <= state_d;
            day_q     <= day_d;
            month_q   <= month_d;
            year_q    <= year_d;
            leap_q    <= leap_d;
            busy_q    <= busy_d;
            wrap_q    <= wrap_d;
            pend_q    <= pend_d;
            rem100_q  <= rem100_d;
            cent_q    <= cent_d;
            r_q       <= r_d;
            day_c_q   <= day_c_d;
            month_c_q <= month_c_d;
            year_c_q  <= year_c_d;
        end
    end

    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign leap      = leap_q;
    assign busy      = busy_q;
    assign year_wrap = wrap_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed plus randomized bench for calendar_date_counter against a
// calendar-arithmetic reference model.
module tb_calendar_date_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        day_tick = 1'b0;
    logic        set_en = 1'b0;
    logic [4:0]  set_day = 5'd0;
    logic [3:0]  set_month = 4'd0;
    logic [11:0] set_year = 12'd0;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic        leap, busy, year_wrap;

    int total = 0;
    int bad = 0;
    int m_day, m_month, m_year;

    calendar_date_counter dut (
        .clk(clk), .rst(rst), .day_tick(day_tick), .set_en(set_en),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .day(day), .month(month), .year(year), .leap(leap),
        .busy(busy), .year_wrap(year_wrap)
    );

    always #5 clk = ~clk;

    function automatic int m_leap(input int y);
        return ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) ? 1 : 0;
    endfunction

    function automatic int m_dim(input int mo, input int y);
        if (mo == 2) return 28 + m_leap(y);
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int exp_busy, input int exp_wrap);
        chk({tag, ".day"},   32'(day),       32'(m_day));
        chk({tag, ".month"}, 32'(month),     32'(m_month));
        chk({tag, ".year"},  32'(year),      32'(m_year));
        chk({tag, ".leap"},  32'(leap),      32'(m_leap(m_year)));
        chk({tag, ".busy"},  32'(busy),      32'(exp_busy));
        chk({tag, ".wrap"},  32'(year_wrap), 32'(exp_wrap));
    endtask

    task automatic adv(output int w);
        w = 0;
        if (m_day < m_dim(m_month, m_year)) m_day++;
        else if (m_month < 12) begin m_day = 1; m_month++; end
        else begin
            m_day = 1; m_month = 1;
            if (m_year == 3999) begin m_year = 2000; w = 1; end
            else m_year++;
        end
    endtask

    task automatic tick(input string tag);
        int w;
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
        adv(w);
        check_all(tag, 0, w);
    endtask

    // tick_at/set_at: busy-cycle index for a stray tick / ignored load (0 = none)
    task automatic do_load(input string tag, input int sd, input int sm, input int sy,
                           input int tick_at, input int set_at, input bit merge,
                           input bit coinc);
        int cd, cm, cy, exp_busy, n, w;
        bit pend;
        logic [4:0] vd; logic [3:0] vm; logic [11:0] vy;
        cm = (sm == 0 || sm > 12) ? 1 : sm;
        cy = (sy < 2000) ? 2000 : (sy > 3999) ? 3999 : sy;
        cd = (sd == 0) ? 1 : sd;
        if (cd > m_dim(cm, cy)) cd = m_dim(cm, cy);
        exp_busy = (cy - 2000) / 100 + 2;
        vd = sd[4:0]; vm = sm[3:0]; vy = sy[11:0];
        set_day = vd; set_month = vm; set_year = vy;
        set_en = 1'b1;
        day_tick = coinc;
        @(negedge clk);
        set_en = 1'b0;
        day_tick = 1'b0;
        n = 0;
        pend = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            check_all({tag, ".hold"}, 1, 0);
            if (n == tick_at) begin day_tick = 1'b1; pend = 1; end
            if (n == set_at) begin
                set_en = 1'b1; set_day = 5'd9; set_month = 4'd9; set_year = 12'd2999;
            end
            @(negedge clk);
            day_tick = 1'b0;
            set_en = 1'b0;
        end
        chk({tag, ".busy_cycles"}, 32'(n), 32'(exp_busy));
        m_day = cd; m_month = cm; m_year = cy;
        check_all({tag, ".loaded"}, 0, 0);
        if (pend || merge) begin
            day_tick = merge;
            @(negedge clk);
            day_tick = 1'b0;
            adv(w);
            check_all({tag, ".pending"}, 0, w);
        end
    endtask

    initial begin
        m_day = 1; m_month = 1; m_year = 2000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_all("reset", 0, 0);

        do_load("l2000", 28, 2, 2000, 0, 0, 0, 0);
        tick("t0229");
        tick("t0301");

        do_load("l2100", 28, 2, 2100, 0, 0, 0, 0);
        tick("t2100");
        do_load("l2400", 30, 2, 2400, 0, 0, 0, 0);

        do_load("l3999", 31, 12, 3999, 0, 0, 0, 0);
        tick("twrap");
        @(negedge clk);
        check_all("wrap_drop", 0, 0);

        do_load("l2023", 0, 13, 2023, 2, 3, 0, 0);
        do_load("l2024", 31, 4, 2024, 0, 0, 0, 0);
        do_load("coinc", 15, 6, 2500, 0, 0, 0, 1);
        @(negedge clk);
        check_all("coinc_idle", 0, 0);
        do_load("merge", 31, 1, 2200, 4, 0, 1, 0);

        set_day = 5'd2; set_month = 4'd3; set_year = 12'd3500;
        set_en = 1'b1;
        @(negedge clk);
        set_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_day = 1; m_month = 1; m_year = 2000;
        check_all("rst_mid", 0, 0);
        @(negedge clk);
        check_all("rst_after", 0, 0);

        do_load("lo_year", 29, 2, 1500, 0, 0, 0, 0);
        do_load("hi_year", 31, 12, 4095, 0, 0, 0, 0);
        tick("hi_wrap");

        for (int i = 0; i < 25; i++) begin
            int sd, sm, sy, nt;
            sd = ($urandom_range(0, 3) == 0) ? 31 : $urandom_range(0, 31);
            sm = $urandom_range(0, 15);
            sy = ($urandom_range(0, 3) == 0) ? 3999 : $urandom_range(1900, 4095);
            do_load("rnd", sd, sm, sy, $urandom_range(0, 4), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            nt = $urandom_range(0, 35);
            for (int k = 0; k < nt; k++) tick("rnd_tick");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
- Sequential date keeper for the millennium clock. Advances day/month/year on a once-per-day tick, with full Gregorian leap-year rules over 2000..3999.
- Its binary `year` output feeds the BCD year converter directly, so `year` must always lie in 2000..3999.
- Also accepts a user date load. A short iterative calculation sequence validates the loaded date and recomputes the leap-year state.

Parameters:
- YEAR_MIN, 2000, lowest representable year; also the reset and wrap target.
- YEAR_MAX, 3999, highest representable year; the next day after Dec 31 wraps to YEAR_MIN.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- day_tick  input  1  one-cycle pulse at midnight; advances the date by one day.
- set_en  input  1  one-cycle load strobe; sampled only when busy=0.
- set_day  input  5  requested day.
- set_month  input  4  requested month.
- set_year  input  12  requested year.
- day  output  5  current day, 1..31.
- month  output  4  current month, 1..12.
- year  output  12  current year, 2000..3999.
- leap  output  1  1 when the current year is a leap year.
- busy  output  1  load sequence in progress.
- year_wrap  output  1  one-cycle pulse when the year wraps 3999 to 2000.

Behaviour:
- Reset (rst=1 at a clk edge): day=1, month=1, year=2000, leap=1, busy=0, year_wrap=0. State goes to RUN; internal rem100=0, cent=0; pending-tick flag cleared. Reset overrides any operation in progress.
- States: RUN, CALC, CLAMP.
- Internal leap bookkeeping:
  - off = year-2000 (0..1999). rem100 = off mod 100. cent = off/100 (0..19).
  - leap = (off[1:0]==0) && (rem100!=0 || cent[1:0]==0).
  - rem100 and cent are maintained incrementally in RUN. No divider is used.
- Days in month (dim): Feb = 28+leap; Apr/Jun/Sep/Nov = 30; all others = 31.
- RUN, day_tick=1, set_en=0. At the next edge:
  - If day<dim: day++.
  - Else, if month<12: day=1, month++.
  - Else (Dec 31): day=1, month=1, year++. rem100 increments, wrapping 99 to 0 with cent++.
  - If year was 3999: year=2000, rem100=0, cent=0, year_wrap=1 for exactly one cycle.
  - leap is updated on the same edge as year.
- RUN, set_en=1. set_en wins over a coincident day_tick; that tick is discarded. Capture and clamp, then go to CALC:
  - set_month 0 or >12 becomes 1.
  - set_year <2000 becomes 2000; set_year >3999 becomes 3999.
  - set_day 0 becomes 1.
  - Working remainder r = year_c-2000; cent counter = 0; busy=1.
- CALC: one step per cycle.
  - If r>=100: r -= 100, cent++.
  - Else: rem100 = r, go to CLAMP.
  - Takes cent_final+1 cycles.
- CLAMP (1 cycle):
  - Compute leap from the new rem100/cent/year.
  - Write year, month, and day = min(day_c, dim), with dim evaluated using the new month and leap.
  - Go to RUN.
- busy timing: busy is high for every cycle spent in CALC or CLAMP (cent_final+2 cycles). It is low from the first RUN cycle onward.
- Output timing: day/month/year/leap keep their old values until the edge that leaves CLAMP.
- set_en while busy=1: ignored.
- day_tick while busy=1: sets the pending flag (at most one is held). The pending tick is applied on the first RUN cycle against the loaded date, then the flag is cleared.
  - If that same first RUN cycle also has day_tick or set_en: a coincident day_tick is merged and the date still advances by exactly one day. A coincident set_en discards the pending tick and starts a new load.
- year_wrap is 0 in all cycles except the wrap cycle.
- Width rules: all year arithmetic is 12-bit unsigned; comparisons are unsigned. No output ever leaves its legal range.

Test Plan:
- Reset, then idle 5 cycles -> day=1, month=1, year=2000, leap=1, busy=0, year_wrap=0.
- Load 2000-02-28 and wait for busy=0, then one tick -> 2000-02-29 (leap=1). Next tick -> 2000-03-01.
- Load 2100-02-28, then tick -> 2100-03-01 with leap=0. Load 2400-02-30 -> busy high for 6 cycles, result 2400-02-29, leap=1.
- Load 3999-12-31, then tick -> 2000-01-01, year_wrap high for exactly one cycle, leap=1.
- Load 2023-13-00 with day_tick asserted in the second busy cycle -> clamped to 2023-01-01, then the pending tick gives 2023-01-02. A set_en pulse mid-busy has no effect.
- Load 2024-04-31 -> 2024-04-30. Assert set_en and day_tick together in RUN -> the load wins, no advance. Assert rst mid-CALC -> reset values on the next cycle, busy=0.
